seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Purpose: recovers the digits shown on a multiplexed 8-digit, active-low 7-segment scan.
//          It debounces each scan slot, decodes the segment pattern and keeps a per-digit image.
// Latency: a slot is accepted on the STABLE_CYCLES-th consecutive edge with an identical {an,hex}.
//          Outputs are registered and update on that same edge.
// Backpressure: none; the input is sampled every cycle and cannot be stalled.
//
// Ports:
//   clock       rising-edge clock for all logic
//   rst         synchronous, active-high reset
//   an[7:0]     digit enables, active-low (one zero bit selects a digit; 8'hFF means none)
//   hex[7:0]    segments, active-low: [6:0] = g..a, [7] = dot
//   digits[31:0] decoded nibble of digit i at [4i+3:4i]
//   dots[7:0]   dot lit, per digit
//   blanks[7:0] digit shown all-off, per digit
//   valid[7:0]  digit captured since reset (or since the last stale event)
//   frame_done  one-cycle pulse when the scan wraps (accepted index <= previous one)
//   err         sticky: multi-digit select or undecodable segment pattern
//   stale       scan has stopped (timeout build only)
//
// Build option: define SEG_SCAN_DECODER_TIMEOUT_EN to enable the stale timeout.
// Without it, stale is held at 0 and captured digits are kept indefinitely.

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 100000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  hex,
  output logic [31:0] digits,
  output logic [7:0]  dots,
  output logic [7:0]  blanks,
  output logic [7:0]  valid,
  output logic        frame_done,
  output logic        err,
  output logic        stale
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  // Previous registered sample, compared against the incoming one.
  logic [7:0] an_q;
  logic [7:0] hex_q;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  logic       accept;
  logic       sel_err;

  // Index tracking for frame wrap detection.
  logic [2:0] last_idx;
  logic       seen_any;

  // Decoded view of the current sample.
  logic [2:0] idx;
  logic       an_one_hot;
  logic       an_none;
  logic       same;
  logic [3:0] dec_val;
  logic       dec_blank;
  logic       dec_bad;
  logic       fd_hit;

  // ---------------------------------------------------------------------------
  // Input classification
  // ---------------------------------------------------------------------------
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
  end

  assign an_none    = (an == 8'hFF);
  assign an_one_hot = ($countones(~an) == 1);

  // IDLE never counts as a match, so the first sample after reset, or after an
  // ignored/illegal select, always starts a fresh count.
  assign same = ({an, hex} == {an_q, hex_q}) && (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    sel_err = 1'b0;
    if (!same) begin
      if (an_one_hot) begin
        // A new pattern counts as its first stable edge.
        cnt_d = 8'd1;
        if (STABLE_W == 8'd1) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          state_d = SETTLE;
        end
      end else begin
        cnt_d   = 8'd0;
        state_d = IDLE;
        sel_err = !an_none;
      end
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == STABLE_W) begin
        accept  = 1'b1;
        state_d = HELD;
      end
    end
    // HELD with an unchanged sample: stay put, the slot was already taken.
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (segment decode and frame wrap detection)
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_val   = 4'hE;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (hex[6:0])
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h7F: begin
        dec_val   = 4'hF;
        dec_blank = 1'b1;
      end
      default: begin
        dec_val = 4'hE;
        dec_bad = 1'b1;
      end
    endcase
    // A scan wraps when the index fails to advance; skipped (all-off) slots
    // never reach here, so partial scans wrap correctly.
    fd_hit = seen_any && (idx <= last_idx);
  end

  // ---------------------------------------------------------------------------
  // Sample register and captured digit image
  // ---------------------------------------------------------------------------
`ifdef SEG_SCAN_DECODER_TIMEOUT_EN
  localparam int         TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  logic [TW-1:0] to_cnt;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      an_q       <= 8'd0;
      hex_q      <= 8'd0;
      digits     <= 32'd0;
      dots       <= 8'd0;
      blanks     <= 8'd0;
      valid      <= 8'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      last_idx   <= 3'd0;
      seen_any   <= 1'b0;
`ifdef SEG_SCAN_DECODER_TIMEOUT_EN
      to_cnt     <= '0;
      stale      <= 1'b0;
`endif
    end else begin
      an_q       <= an;
      hex_q      <= hex;
      frame_done <= 1'b0;
      if (sel_err) err <= 1'b1;

      if (accept) begin
        digits[{idx, 2'b00} +: 4] <= dec_val;
        dots[idx]   <= ~hex[7];
        blanks[idx] <= dec_blank;
        valid[idx]  <= 1'b1;
        if (dec_bad) err <= 1'b1;
        frame_done  <= fd_hit;
        last_idx    <= idx;
        seen_any    <= 1'b1;
      end

`ifdef SEG_SCAN_DECODER_TIMEOUT_EN
      if (accept) begin
        to_cnt <= '0;
        stale  <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
        // Going stale forgets the image and the wrap reference, so the next
        // scan starts over as if after reset.
        if (to_cnt == TO_MAX - TW'(1)) begin
          stale    <= 1'b1;
          valid    <= 8'd0;
          seen_any <= 1'b0;
        end
      end
`endif
    end
  end

`ifndef SEG_SCAN_DECODER_TIMEOUT_EN
  // No timeout in this build; TIMEOUT is a positive count so this is constant 0.
  assign stale = (TIMEOUT < 0);
`endif

endmodule
